// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: receive-side alignment and symbol decode for one colour channel.
// Raw 10-bit words from the deserializer are windowed against the previous
// word, bit-slipped until a run of control tokens is found, then decoded back
// into pixel data (DE=1) or control bits C0/C1 (DE=0). Locked reports the
// alignment state to the link-status logic.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT   = 16,
  parameter int SLIP_TIMEOUT = 1024,
  parameter int MAX_RUN      = 2048
) (
  input  logic       PixClk,
  input  logic       nReset,
  input  logic [9:0] RawSymbol,
  output logic [7:0] Data,
  output logic       C0,
  output logic       C1,
  output logic       DE,
  output logic       Locked,
  output logic [3:0] Offset
);

  // Counters are sized to hold their terminal value and saturate there.
  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(SLIP_TIMEOUT + 1);
  localparam int RUN_W  = $clog2(MAX_RUN + 1);

  localparam logic [HIT_W-1:0]  HIT_ONE   = HIT_W'(1);
  localparam logic [HIT_W-1:0]  HIT_SAT   = '1;
  localparam logic [HIT_W-1:0]  HIT_LOCK  = HIT_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_SAT  = '1;
  localparam logic [MISS_W-1:0] MISS_SLIP = MISS_W'(SLIP_TIMEOUT - 1);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0]  RUN_SAT   = '1;
  localparam logic [RUN_W-1:0]  RUN_LOST  = RUN_W'(MAX_RUN);

  // Alignment FSM states.
  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // The four TMDS control tokens, written MSB first (bit 0 is sent first).
  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_10 = 10'b0010101011;
  localparam logic [9:0] TOK_01 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  function automatic logic [HIT_W-1:0] sat_inc_hit(input logic [HIT_W-1:0] v);
    return (v == HIT_SAT) ? v : v + HIT_ONE;
  endfunction

  function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
    return (v == MISS_SAT) ? v : v + MISS_ONE;
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v == RUN_SAT) ? v : v + RUN_ONE;
  endfunction

  // Bit-slip offset walks 0..9 and wraps.
  function automatic logic [3:0] next_offset(input logic [3:0] off);
    return (off == 4'd9) ? 4'd0 : off + 4'd1;
  endfunction

  // Undo the transition-minimising stage of the TMDS encoder.
  function automatic logic [7:0] decode_data(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d    = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [9:0]        prev_word;
  logic [HIT_W-1:0]  hit_cnt;
  logic [HIT_W-1:0]  hit_nxt;
  logic [HIT_W-1:0]  hit_inc;
  logic [MISS_W-1:0] miss_cnt;
  logic [MISS_W-1:0] miss_nxt;
  logic [MISS_W-1:0] miss_inc;
  logic [RUN_W-1:0]  run_cnt;
  logic [RUN_W-1:0]  run_nxt;
  logic [RUN_W-1:0]  run_inc;
  logic [3:0]        offset_nxt;
  logic [7:0]        data_nxt;
  logic              c0_nxt;
  logic              c1_nxt;
  logic              de_nxt;
  logic              locked_nxt;

  // Window stage: offset 9 needs bits [18:9], so RawSymbol[9] never reaches the window.
  logic [18:0] win;
  logic [9:0]  sym;
  logic        is_ctrl;
  logic        tok_c0;
  logic        tok_c1;
  logic [7:0]  sym_data;

  assign win      = {RawSymbol[8:0], prev_word};
  assign hit_inc  = sat_inc_hit(hit_cnt);
  assign miss_inc = sat_inc_miss(miss_cnt);
  assign run_inc  = sat_inc_run(run_cnt);
  assign sym_data = decode_data(sym);

  // Select the 10-bit symbol at the current bit-slip offset.
  always_comb begin
    sym = win[9:0];
    case (Offset)
      4'd0:    sym = win[9:0];
      4'd1:    sym = win[10:1];
      4'd2:    sym = win[11:2];
      4'd3:    sym = win[12:3];
      4'd4:    sym = win[13:4];
      4'd5:    sym = win[14:5];
      4'd6:    sym = win[15:6];
      4'd7:    sym = win[16:7];
      4'd8:    sym = win[17:8];
      4'd9:    sym = win[18:9];
      default: sym = win[9:0];
    endcase
  end

  // Classify the windowed symbol as one of the four control tokens.
  always_comb begin
    is_ctrl = 1'b0;
    tok_c0  = 1'b0;
    tok_c1  = 1'b0;
    case (sym)
      TOK_00: begin is_ctrl = 1'b1; tok_c0 = 1'b0; tok_c1 = 1'b0; end
      TOK_10: begin is_ctrl = 1'b1; tok_c0 = 1'b1; tok_c1 = 1'b0; end
      TOK_01: begin is_ctrl = 1'b1; tok_c0 = 1'b0; tok_c1 = 1'b1; end
      TOK_11: begin is_ctrl = 1'b1; tok_c0 = 1'b1; tok_c1 = 1'b1; end
      default: begin is_ctrl = 1'b0; tok_c0 = 1'b0; tok_c1 = 1'b0; end
    endcase
  end

  // Alignment FSM and output decode: next-state computation.
  always_comb begin
    state_nxt  = state;
    hit_nxt    = hit_cnt;
    miss_nxt   = miss_cnt;
    run_nxt    = run_cnt;
    offset_nxt = Offset;
    data_nxt   = Data;
    c0_nxt     = C0;
    c1_nxt     = C1;
    de_nxt     = DE;
    locked_nxt = Locked;
    case (state)
      ST_SEARCH: begin
        // Outputs stay quiet until alignment is established.
        data_nxt   = '0;
        c0_nxt     = 1'b0;
        c1_nxt     = 1'b0;
        de_nxt     = 1'b0;
        locked_nxt = 1'b0;
        miss_nxt   = miss_inc;
        hit_nxt    = is_ctrl ? hit_inc : '0;
        if (is_ctrl && (hit_inc == HIT_LOCK)) begin
          // Lock wins over a slip falling due in the same cycle.
          state_nxt  = ST_LOCKED;
          locked_nxt = 1'b1;
          hit_nxt    = '0;
          miss_nxt   = '0;
          run_nxt    = '0;
        end else if (miss_cnt == MISS_SLIP) begin
          offset_nxt = next_offset(Offset);
          hit_nxt    = '0;
          miss_nxt   = '0;
        end
      end
      default: begin
        locked_nxt = 1'b1;
        if (is_ctrl) begin
          de_nxt   = 1'b0;
          c0_nxt   = tok_c0;
          c1_nxt   = tok_c1;
          data_nxt = '0;
          run_nxt  = '0;
        end else if (run_inc == RUN_LOST) begin
          // Too long without a control token: alignment is presumed lost.
          state_nxt  = ST_SEARCH;
          locked_nxt = 1'b0;
          data_nxt   = '0;
          c0_nxt     = 1'b0;
          c1_nxt     = 1'b0;
          de_nxt     = 1'b0;
          hit_nxt    = '0;
          miss_nxt   = '0;
          run_nxt    = '0;
        end else begin
          // C0/C1 hold their last token value through data periods.
          de_nxt   = 1'b1;
          data_nxt = sym_data;
          run_nxt  = run_inc;
        end
      end
    endcase
  end

  // Register stage: previous word, alignment state and decoded outputs.
  always_ff @(posedge PixClk or negedge nReset) begin
    if (!nReset) begin
      prev_word <= '0;
      state     <= ST_SEARCH;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      run_cnt   <= '0;
      Offset    <= '0;
      Data      <= '0;
      C0        <= 1'b0;
      C1        <= 1'b0;
      DE        <= 1'b0;
      Locked    <= 1'b0;
    end else begin
      prev_word <= RawSymbol;
      state     <= state_nxt;
      hit_cnt   <= hit_nxt;
      miss_cnt  <= miss_nxt;
      run_cnt   <= run_nxt;
      Offset    <= offset_nxt;
      Data      <= data_nxt;
      C0        <= c0_nxt;
      C1        <= c1_nxt;
      DE        <= de_nxt;
      Locked    <= locked_nxt;
    end
  end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the per-channel TMDS component encoder.
- Takes raw 10-bit words from the channel deserializer, whose word boundary may be arbitrary.
- Finds symbol alignment by bit-slipping until it sees runs of control tokens, then decodes symbols back to Data/C0/C1/DE in the PixClk domain.
- One instance per colour channel; Locked feeds the link-status logic.

Parameters:
- LOCK_COUNT, 16: number of consecutive control tokens at the current offset that declares lock.
- SLIP_TIMEOUT, 1024: number of SEARCH cycles without lock before Offset advances by one bit.
- MAX_RUN, 2048: number of consecutive non-control symbols while LOCKED that declares lock lost.

Ports:
- PixClk  in  1  pixel clock; all logic on posedge.
- nReset  in  1  reset; asynchronous, active-low.
- RawSymbol  in  10  deserialized word; bit 0 is the earliest received bit.
- Data  out  8  decoded pixel byte.
- C0  out  1  decoded control bit 0.
- C1  out  1  decoded control bit 1.
- DE  out  1  1 while the output is a decoded data symbol.
- Locked  out  1  alignment state is LOCKED.
- Offset  out  4  current bit-slip offset, 0..9.

Behaviour:
- Reset (nReset=0, asynchronous):
  - Data=0, C0=0, C1=0, DE=0, Locked=0, Offset=0.
  - Prev=0, HitCnt=0, MissCnt=0, RunCnt=0, state=SEARCH.
- Window:
  - Each posedge, Prev <= RawSymbol.
  - Sym (combinational) = bits [Offset+9:Offset] of the 20-bit concatenation {RawSymbol, Prev}.
  - Offset 0 gives Sym = Prev.
- Latency: a symbol wholly contained in the word presented at edge n (Offset 0) appears on the outputs after edge n+1.
- Control token classification (exact match on Sym):
  - 1101010100 -> C0=0, C1=0.
  - 0010101011 -> C0=1, C1=0.
  - 0101010100 -> C0=0, C1=1.
  - 1010101011 -> C0=1, C1=1.
- Data decode:
  - q = Sym[9] ? ~Sym[7:0] : Sym[7:0].
  - Data[0] = q[0].
  - For i=1..7: Data[i] = q[i]^q[i-1] when Sym[8]=1, else ~(q[i]^q[i-1]).
- Counter widths: ceil(log2(max+1)) of their respective parameter; counters saturate and never wrap.
- SEARCH state:
  - Outputs are held at DE=0, Data=0, C0=0, C1=0; Locked=0.
  - MissCnt increments every cycle.
  - Sym is a control token -> HitCnt+1; otherwise HitCnt=0.
  - If HitCnt reaches LOCK_COUNT (the hit that makes it LOCK_COUNT) -> LOCKED; clear HitCnt, MissCnt and RunCnt.
  - Else if MissCnt reaches SLIP_TIMEOUT-1 -> slip: Offset <= (Offset==9) ? 0 : Offset+1; clear HitCnt and MissCnt.
  - Lock has priority over slip in the same cycle.
  - The new Offset is used for the next cycle's Sym.
- LOCKED state:
  - Locked=1.
  - Control token: DE<=0, C0/C1 <= token value, Data<=0, RunCnt<=0.
  - Non-control symbol: DE<=1, Data<=decoded value, C0/C1 hold, RunCnt+1.
  - RunCnt reaching MAX_RUN -> SEARCH: Locked<=0, outputs forced to reset values, Offset unchanged, HitCnt and MissCnt cleared.
- Locked rises in the same edge as the state change. The first decoded output in LOCKED is the symbol after the locking token.
- Offset changes only in SEARCH.
- nReset asserted mid-operation: immediate return to reset values regardless of state. No residual alignment is retained.

Test Plan:
- Reset: hold nReset=0, toggle RawSymbol randomly -> all outputs 0, Offset=0, Locked=0 throughout.
- Aligned lock: after reset, drive 1101010100 every cycle -> Locked=1 after the 16th token edge; then C0=0, C1=0, DE=0; Offset stays 0.
- Decode after lock:
  - 0100000000 -> DE=1, Data=0x00.
  - 1000000000 -> DE=1, Data=0xFF.
  - then 0010101011 -> DE=0, C0=1, C1=0.
  - Data appears 2 edges after presentation.
- Misaligned stream:
  - Bit stream of repeating 1010101011 delayed by 3 bits across word boundaries -> Offset steps 0,1,2 at SLIP_TIMEOUT intervals.
  - Lock at Offset=3, then C0=1, C1=1.
  - Also test delay 9: Offset reaches 9. With a non-lockable stream, Offset wraps 9->0.
- Lock loss: when LOCKED, 2048 consecutive 0100000000 -> Locked drops at the 2048th; outputs zero; re-lock on the following 16 tokens.
- Reset mid-lock: assert nReset asynchronously between edges while LOCKED with DE=1 -> outputs and Locked clear immediately; re-lock requires a full 16-token run.
